// File: rtl/ccu_snoop_cd_responder_if.sv
// Snoop-port bundle between the CCU (master) and the cache-side snoop responder (slave).
// Carries AC/CR/CD channels plus the dcache lookup and state-update sidebands.
interface ccu_snoop_cd_responder_if #(
    parameter int DcacheLineWidth = 128,
    parameter int AxiDataWidth    = 64,
    parameter int AddrWidth       = 64
);
    logic                       ac_valid;
    logic                       ac_ready;
    logic [AddrWidth-1:0]       ac_addr;
    logic [3:0]                 ac_snoop;
    logic                       cr_valid;
    logic                       cr_ready;
    logic [4:0]                 cr_resp;
    logic                       cd_valid;
    logic                       cd_ready;
    logic [AxiDataWidth-1:0]    cd_data;
    logic                       cd_last;
    logic                       lookup_req;
    logic                       lookup_gnt;
    logic [AddrWidth-1:0]       lookup_addr;
    logic                       lookup_valid;
    logic                       lookup_hit;
    logic                       lookup_dirty;
    logic                       lookup_shared;
    logic [DcacheLineWidth-1:0] lookup_data;
    logic                       update_req;
    logic                       update_gnt;
    logic [1:0]                 update_state;

    modport slave (
        input  ac_valid, ac_addr, ac_snoop, cr_ready, cd_ready, lookup_gnt, lookup_valid,
               lookup_hit, lookup_dirty, lookup_shared, lookup_data, update_gnt,
        output ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last, lookup_req,
               lookup_addr, update_req, update_state
    );

    modport master (
        output ac_valid, ac_addr, ac_snoop, cr_ready, cd_ready, lookup_gnt, lookup_valid,
               lookup_hit, lookup_dirty, lookup_shared, lookup_data, update_gnt,
        input  ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last, lookup_req,
               lookup_addr, update_req, update_state
    );
endinterface

// File: rtl/ccu_snoop_cd_responder.sv
// Cache-side ACE snoop responder: AC accept, dcache lookup, optional state update, CR then CD beats.
// Define CCU_SNOOP_CR_CD_OVERLAP_EN to issue CR and CD concurrently when data is transferred.
//
// state    | meaning
// IDLE     | ac_ready high, waiting for a snoop
// LOOKUP   | lookup_req high until granted
// WAIT_RES | waiting for lookup result, decode response
// UPDATE   | update_req high until granted
// SEND_CR  | cr_valid high (and CD beats too when overlapped)
// SEND_CD  | streaming line beats, word 0 first
module ccu_snoop_cd_responder #(
    parameter int DcacheLineWidth = 128,
    parameter int AxiDataWidth    = 64,
    parameter int AddrWidth       = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    ccu_snoop_cd_responder_if.slave bus
);
    localparam int LineWords  = DcacheLineWidth / AxiDataWidth;
    localparam int OffsetBits = $clog2(DcacheLineWidth / 8);
    localparam int CntWidth   = $clog2(LineWords);
`ifdef CCU_SNOOP_CR_CD_OVERLAP_EN
    localparam bit Overlap = 1'b1;
`else
    localparam bit Overlap = 1'b0;
`endif

    localparam logic [3:0] SnpReadOnce     = 4'b0000;
    localparam logic [3:0] SnpReadShared   = 4'b0001;
    localparam logic [3:0] SnpReadUnique   = 4'b0111;
    localparam logic [3:0] SnpCleanInvalid = 4'b1001;
    localparam logic [3:0] SnpMakeInvalid  = 4'b1101;
    localparam logic [1:0] StInvalid       = 2'b00;
    localparam logic [1:0] StSharedClean   = 2'b01;

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_RES, UPDATE, SEND_CR, SEND_CD} state_t;

    state_t                     state;
    logic [3:0]                 snoop;
    logic [DcacheLineWidth-1:0] line_buf;
    logic [CntWidth-1:0]        cnt;
    logic                       dt;
    logic                       ac_ready, cr_valid, cd_valid, cd_last, lookup_req, update_req;
    logic [4:0]                 cr_resp;
    logic [AxiDataWidth-1:0]    cd_data;
    logic [AddrWidth-1:0]       lookup_addr;
    logic [1:0]                 update_state;

    logic [4:0] dec_cr;
    logic       dec_upd;
    logic [1:0] dec_state;
    logic       hit, dirty, nshared;

    assign hit     = bus.lookup_hit;
    assign dirty   = bus.lookup_dirty;
    assign nshared = !bus.lookup_shared;

    // cr bits: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    always_comb begin
        dec_cr    = 5'b00000;
        dec_upd   = 1'b0;
        dec_state = StInvalid;
        case (snoop)
            SnpReadOnce: if (hit) dec_cr = {nshared, 1'b1, 1'b0, 1'b0, 1'b1};
            SnpReadShared: if (hit) begin
                dec_cr    = {nshared, 1'b1, dirty, 1'b0, 1'b1};
                dec_upd   = dirty || nshared;
                dec_state = StSharedClean;
            end
            SnpReadUnique: if (hit) begin
                dec_cr  = {nshared, 1'b0, dirty, 1'b0, 1'b1};
                dec_upd = 1'b1;
            end
            SnpCleanInvalid: if (hit) begin
                dec_cr  = {nshared, 1'b0, dirty, 1'b0, dirty};
                dec_upd = 1'b1;
            end
            SnpMakeInvalid: if (hit) begin
                dec_cr  = {nshared, 1'b0, 1'b0, 1'b0, 1'b0};
                dec_upd = 1'b1;
            end
            default: dec_cr = 5'b00010;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            snoop        <= '0;
            line_buf     <= '0;
            cnt          <= '0;
            dt           <= 1'b0;
            ac_ready     <= 1'b0;
            cr_valid     <= 1'b0;
            cr_resp      <= '0;
            cd_valid     <= 1'b0;
            cd_data      <= '0;
            cd_last      <= 1'b0;
            lookup_req   <= 1'b0;
            lookup_addr  <= '0;
            update_req   <= 1'b0;
            update_state <= StInvalid;
        end else begin
            // Beat engine runs whenever CD is valid, shared by both CR/CD orderings.
            if (cd_valid && bus.cd_ready) begin
                if (cd_last) begin
                    cd_valid <= 1'b0;
                    cd_last  <= 1'b0;
                    cd_data  <= '0;
                    cnt      <= '0;
                end else begin
                    cnt      <= cnt + 1'b1;
                    cd_data  <= line_buf[AxiDataWidth +: AxiDataWidth];
                    line_buf <= line_buf >> AxiDataWidth;
                    cd_last  <= (cnt == CntWidth'(LineWords - 2));
                end
            end
            if (cr_valid && bus.cr_ready) begin
                cr_valid <= 1'b0;
                cr_resp  <= '0;
            end
            case (state)
                IDLE: begin
                    if (ac_ready && bus.ac_valid) begin
                        ac_ready    <= 1'b0;
                        snoop       <= bus.ac_snoop;
                        lookup_req  <= 1'b1;
                        lookup_addr <= {bus.ac_addr[AddrWidth-1:OffsetBits], OffsetBits'(0)};
                        state       <= LOOKUP;
                    end else begin
                        ac_ready <= 1'b1;
                    end
                end
                LOOKUP: if (bus.lookup_gnt) begin
                    lookup_req  <= 1'b0;
                    lookup_addr <= '0;
                    state       <= WAIT_RES;
                end
                WAIT_RES: if (bus.lookup_valid) begin
                    line_buf <= bus.lookup_data;
                    cr_resp  <= dec_cr;
                    dt       <= dec_cr[0];
                    if (dec_upd) begin
                        update_req   <= 1'b1;
                        update_state <= dec_state;
                        state        <= UPDATE;
                    end else begin
                        cr_valid <= 1'b1;
                        state    <= SEND_CR;
                        if (Overlap && dec_cr[0]) begin
                            cd_valid <= 1'b1;
                            cd_data  <= bus.lookup_data[AxiDataWidth-1:0];
                        end
                    end
                end
                UPDATE: if (bus.update_gnt) begin
                    update_req   <= 1'b0;
                    update_state <= StInvalid;
                    cr_valid     <= 1'b1;
                    state        <= SEND_CR;
                    if (Overlap && dt) begin
                        cd_valid <= 1'b1;
                        cd_data  <= line_buf[AxiDataWidth-1:0];
                    end
                end
                SEND_CR: begin
                    if (Overlap) begin
                        if ((!cr_valid || bus.cr_ready) && (!cd_valid || (bus.cd_ready && cd_last))) begin
                            ac_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else if (bus.cr_ready) begin
                        if (dt) begin
                            cd_valid <= 1'b1;
                            cd_data  <= line_buf[AxiDataWidth-1:0];
                            state    <= SEND_CD;
                        end else begin
                            ac_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                SEND_CD: if (bus.cd_ready && cd_last) begin
                    ac_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ac_ready     = ac_ready;
    assign bus.cr_valid     = cr_valid;
    assign bus.cr_resp      = cr_resp;
    assign bus.cd_valid     = cd_valid;
    assign bus.cd_data      = cd_data;
    assign bus.cd_last      = cd_last;
    assign bus.lookup_req   = lookup_req;
    assign bus.lookup_addr  = lookup_addr;
    assign bus.update_req   = update_req;
    assign bus.update_state = update_state;
endmodule
